hazard_stall_controller: RTL and testbench



---
 rtl/hazard_stall_controller.sv | 73 +++++++
 tb/tb_hazard_stall_controller.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline hazard sequencer for a 5-stage MIPS.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   rsID/rtID, usesRs/Rt ID-stage source registers and their use flags
//   branchID, mdReadID   ID instruction resolves in ID / needs HI/LO unit
//   destIDEX/weIDEX/reIDEX   EX-stage producer (dest, writes, is load)
//   destEXMEM/reEXMEM    MEM-stage producer (dest, is load)
//   mdStartEX/mdDivEX    mult/div issue pulse and divide select
//   mispredictEX         EX-resolved branch mispredict
//   stallFront           hold PC and IF/ID
//   bubbleIDEX           insert NOP into ID/EX
//   flushIFID            squash IF/ID
//   mdBusy/mdCount       HI/LO unit occupancy and remaining cycles
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             usesRsID,
    input  logic             usesRtID,
    input  logic             branchID,
    input  logic             mdReadID,
    input  logic [4:0]       destIDEX,
    input  logic             weIDEX,
    input  logic             reIDEX,
    input  logic [4:0]       destEXMEM,
    input  logic             reEXMEM,
    input  logic             mdStartEX,
    input  logic             mdDivEX,
    input  logic             mispredictEX,
    output logic             stallFront,
    output logic             bubbleIDEX,
    output logic             flushIFID,
    output logic             mdBusy,
    output logic [CNT_W-1:0] mdCount
);
    typedef enum logic {IDLE, BRWAIT} state_t;
    state_t state;
    logic hit_ex, hit_mem, lu, br_ex, br_ld2, br_mem, md, hazard;
    // $0 is hardwired, so a zero destination never matches
    assign hit_ex  = (destIDEX != 5'd0) &
                     ((usesRsID && rsID == destIDEX) || (usesRtID && rtID == destIDEX));
    assign hit_mem = (destEXMEM != 5'd0) &
                     ((usesRsID && rsID == destEXMEM) || (usesRtID && rtID == destEXMEM));
    assign lu      = reIDEX & weIDEX & hit_ex;
    assign br_ex   = branchID & weIDEX & ~reIDEX & hit_ex;
    // a branch waiting on a load in EX needs the load to reach WB: two stalls
    assign br_ld2  = branchID & reIDEX & weIDEX & hit_ex;
    assign br_mem  = branchID & reEXMEM & hit_mem;
    assign md      = mdReadID & (mdBusy | mdStartEX);
    assign hazard  = lu | br_ex | br_ld2 | br_mem | md | (state == BRWAIT);
    // a mispredict squashes the younger instructions, so stalling them is moot
    assign stallFront = hazard & ~mispredictEX;
    assign bubbleIDEX = stallFront | mispredictEX;
    assign flushIFID  = mispredictEX;
    assign mdBusy     = (mdCount != '0);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mdCount <= '0;
        end else begin
            state   <= (!mispredictEX && state == IDLE && br_ld2) ? BRWAIT : IDLE;
            // the mult/div is older than any mispredicted branch, so it keeps counting
            mdCount <= mdStartEX ? (mdDivEX ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1))
                     : mdBusy    ? mdCount - 1'b1
                     : '0;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed self-checking bench for hazard_stall_controller.
module tb_hazard_stall_controller;
    logic       clock = 0, reset = 1;
    logic [4:0] rsID, rtID, destIDEX, destEXMEM;
    logic       usesRsID, usesRtID, branchID, mdReadID, weIDEX, reIDEX, reEXMEM;
    logic       mdStartEX, mdDivEX, mispredictEX;
    logic       stallFront, bubbleIDEX, flushIFID, mdBusy;
    logic [5:0] mdCount;
    int checks = 0, errors = 0;

    hazard_stall_controller #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .rsID(rsID), .rtID(rtID),
        .usesRsID(usesRsID), .usesRtID(usesRtID), .branchID(branchID), .mdReadID(mdReadID),
        .destIDEX(destIDEX), .weIDEX(weIDEX), .reIDEX(reIDEX),
        .destEXMEM(destEXMEM), .reEXMEM(reEXMEM),
        .mdStartEX(mdStartEX), .mdDivEX(mdDivEX), .mispredictEX(mispredictEX),
        .stallFront(stallFront), .bubbleIDEX(bubbleIDEX), .flushIFID(flushIFID),
        .mdBusy(mdBusy), .mdCount(mdCount)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        rsID = 0; rtID = 0; destIDEX = 0; destEXMEM = 0;
        usesRsID = 0; usesRtID = 0; branchID = 0; mdReadID = 0;
        weIDEX = 0; reIDEX = 0; reEXMEM = 0;
        mdStartEX = 0; mdDivEX = 0; mispredictEX = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        checks++;
        if ({stallFront, bubbleIDEX, flushIFID, mdBusy, mdCount} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got s=%b b=%b f=%b busy=%b cnt=%0d want all 0",
                     stallFront, bubbleIDEX, flushIFID, mdBusy, mdCount);
        end
        step();
        reset = 0;
        step();
    endtask

    task automatic test_load_use();
        idle_inputs();
        reIDEX = 1; weIDEX = 1; destIDEX = 2; rsID = 2; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 1 || bubbleIDEX !== 1 || flushIFID !== 0) begin
            errors++;
            $display("FAIL lu_rs got s=%b b=%b f=%b want 1 1 0", stallFront, bubbleIDEX, flushIFID);
        end
        step();
        idle_inputs();
        rsID = 2; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 0 || bubbleIDEX !== 0) begin
            errors++;
            $display("FAIL lu_release got s=%b b=%b want 0 0", stallFront, bubbleIDEX);
        end
        idle_inputs();
        reIDEX = 1; weIDEX = 1; destIDEX = 7; rtID = 7; usesRtID = 1;
        #1;
        checks++;
        if (stallFront !== 1) begin
            errors++;
            $display("FAIL lu_rt got s=%b want 1", stallFront);
        end
        usesRtID = 0;
        #1;
        checks++;
        if (stallFront !== 0) begin
            errors++;
            $display("FAIL lu_unused_rt got s=%b want 0", stallFront);
        end
        idle_inputs();
        reIDEX = 1; weIDEX = 1; destIDEX = 0; rsID = 0; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 0 || bubbleIDEX !== 0) begin
            errors++;
            $display("FAIL lu_reg0 got s=%b b=%b want 0 0", stallFront, bubbleIDEX);
        end
        step();
    endtask

    task automatic test_branch();
        // beq on $5 behind lw $5 in EX: two stall cycles, second from BRWAIT alone
        idle_inputs();
        branchID = 1; rsID = 5; usesRsID = 1; reIDEX = 1; weIDEX = 1; destIDEX = 5;
        #1;
        checks++;
        if (stallFront !== 1) begin
            errors++;
            $display("FAIL br_ld2_c1 got s=%b want 1", stallFront);
        end
        step();
        idle_inputs();
        branchID = 1; rsID = 5; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 1 || bubbleIDEX !== 1) begin
            errors++;
            $display("FAIL br_ld2_c2 got s=%b b=%b want 1 1", stallFront, bubbleIDEX);
        end
        step();
        #1;
        checks++;
        if (stallFront !== 0) begin
            errors++;
            $display("FAIL br_ld2_c3 got s=%b want 0", stallFront);
        end
        // add $5 in EX: one cycle
        idle_inputs();
        branchID = 1; rsID = 5; usesRsID = 1; weIDEX = 1; destIDEX = 5;
        #1;
        checks++;
        if (stallFront !== 1) begin
            errors++;
            $display("FAIL br_ex_c1 got s=%b want 1", stallFront);
        end
        step();
        idle_inputs();
        branchID = 1; rsID = 5; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 0) begin
            errors++;
            $display("FAIL br_ex_c2 got s=%b want 0", stallFront);
        end
        // lw $5 in MEM only: one cycle, no BRWAIT afterwards
        idle_inputs();
        branchID = 1; rtID = 5; usesRtID = 1; reEXMEM = 1; destEXMEM = 5;
        #1;
        checks++;
        if (stallFront !== 1) begin
            errors++;
            $display("FAIL br_mem_c1 got s=%b want 1", stallFront);
        end
        step();
        idle_inputs();
        branchID = 1; rtID = 5; usesRtID = 1;
        #1;
        checks++;
        if (stallFront !== 0) begin
            errors++;
            $display("FAIL br_mem_c2 got s=%b want 0", stallFront);
        end
        // non-branch with load in MEM is forwarded, no stall
        idle_inputs();
        rtID = 5; usesRtID = 1; reEXMEM = 1; destEXMEM = 5;
        #1;
        checks++;
        if (stallFront !== 0) begin
            errors++;
            $display("FAIL nonbr_mem got s=%b want 0", stallFront);
        end
        step();
    endtask

    task automatic test_div();
        idle_inputs();
        mdStartEX = 1; mdDivEX = 1; mdReadID = 1;
        #1;
        checks++;
        if (stallFront !== 1 || mdBusy !== 0) begin
            errors++;
            $display("FAIL div_start got s=%b busy=%b want 1 0", stallFront, mdBusy);
        end
        step();
        mdStartEX = 0; mdDivEX = 0;
        for (int i = 31; i >= 1; i--) begin
            #1;
            checks++;
            if (mdCount !== 6'(i) || mdBusy !== 1 || stallFront !== 1) begin
                errors++;
                $display("FAIL div_count got cnt=%0d busy=%b s=%b want cnt=%0d busy=1 s=1",
                         mdCount, mdBusy, stallFront, i);
            end
            step();
        end
        #1;
        checks++;
        if (mdCount !== 0 || mdBusy !== 0 || stallFront !== 0) begin
            errors++;
            $display("FAIL div_done got cnt=%0d busy=%b s=%b want 0 0 0", mdCount, mdBusy, stallFront);
        end
        step();
        checks++;
        if (mdCount !== 0) begin
            errors++;
            $display("FAIL div_saturate got cnt=%0d want 0", mdCount);
        end
    endtask

    task automatic test_mult_mispredict();
        idle_inputs();
        mdStartEX = 1;
        step();
        idle_inputs();
        checks++;
        if (mdCount !== 3) begin
            errors++;
            $display("FAIL mult_load got cnt=%0d want 3", mdCount);
        end
        step();
        mispredictEX = 1; mdReadID = 1;
        #1;
        checks++;
        if (mdCount !== 2 || flushIFID !== 1 || bubbleIDEX !== 1 || stallFront !== 0) begin
            errors++;
            $display("FAIL mult_mispredict got cnt=%0d f=%b b=%b s=%b want 2 1 1 0",
                     mdCount, flushIFID, bubbleIDEX, stallFront);
        end
        step();
        idle_inputs();
        checks++;
        if (mdCount !== 1 || flushIFID !== 0) begin
            errors++;
            $display("FAIL mult_after_mp got cnt=%0d f=%b want 1 0", mdCount, flushIFID);
        end
        step();
        checks++;
        if (mdCount !== 0 || mdBusy !== 0) begin
            errors++;
            $display("FAIL mult_done got cnt=%0d busy=%b want 0 0", mdCount, mdBusy);
        end
    endtask

    task automatic test_brwait_mispredict();
        idle_inputs();
        branchID = 1; rsID = 9; usesRsID = 1; reIDEX = 1; weIDEX = 1; destIDEX = 9;
        step();
        idle_inputs();
        mispredictEX = 1;
        #1;
        checks++;
        if (flushIFID !== 1 || bubbleIDEX !== 1 || stallFront !== 0) begin
            errors++;
            $display("FAIL brwait_mp got f=%b b=%b s=%b want 1 1 0", flushIFID, bubbleIDEX, stallFront);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (stallFront !== 0 || bubbleIDEX !== 0 || flushIFID !== 0) begin
            errors++;
            $display("FAIL brwait_mp_after got s=%b b=%b f=%b want 0 0 0", stallFront, bubbleIDEX, flushIFID);
        end
        step();
    endtask

    task automatic test_lu_md();
        idle_inputs();
        mdStartEX = 1;
        step();
        idle_inputs();
        mdReadID = 1; reIDEX = 1; weIDEX = 1; destIDEX = 3; rsID = 3; usesRsID = 1;
        #1;
        checks++;
        if (stallFront !== 1 || bubbleIDEX !== 1) begin
            errors++;
            $display("FAIL lu_md got s=%b b=%b want 1 1", stallFront, bubbleIDEX);
        end
        step();
        step();
        step();
        idle_inputs();
        mdReadID = 1;
        #1;
        checks++;
        if (mdCount !== 0 || stallFront !== 0) begin
            errors++;
            $display("FAIL lu_md_end got cnt=%0d s=%b want 0 0", mdCount, stallFront);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        mdStartEX = 1; mdDivEX = 1;
        step();
        idle_inputs();
        for (int i = 0; i < 13; i++) step();
        branchID = 1; rsID = 4; usesRsID = 1; reIDEX = 1; weIDEX = 1; destIDEX = 4;
        step();
        idle_inputs();
        #1;
        checks++;
        if (mdCount !== 17 || stallFront !== 1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d s=%b want 17 1", mdCount, stallFront);
        end
        #1 reset = 1;
        #1;
        checks++;
        if (mdCount !== 0 || mdBusy !== 0 || stallFront !== 0 || bubbleIDEX !== 0 || flushIFID !== 0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d busy=%b s=%b b=%b f=%b want all 0",
                     mdCount, mdBusy, stallFront, bubbleIDEX, flushIFID);
        end
        step();
        reset = 0;
        step();
        checks++;
        if (stallFront !== 0 || mdCount !== 0) begin
            errors++;
            $display("FAIL post_reset got s=%b cnt=%0d want 0 0", stallFront, mdCount);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_div();
        test_mult_mispredict();
        test_brwait_mispredict();
        test_lu_md();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
